// File: rtl/matvec_pkg.sv
// Shared types and sizing for the matrix-vector stream coprocessor.
package matvec_pkg;

  typedef enum logic [1:0] {
    READ_INPUTS,
    COMPUTE,
    WRITE_OUTPUTS
  } state_t;

  localparam int A_ROWS_DEF = 2;
  localparam int A_COLS_DEF = 4;
  localparam int ELEM_W_DEF = 8;

  // Wide enough to sum A_COLS full-scale products without overflow.
  function automatic int acc_width(input int elem_w, input int cols);
    return 2 * elem_w + $clog2(cols);
  endfunction

endpackage

// File: rtl/matvec_mac.sv
// Registered multiply-accumulate with clear, plus the >>8 result stage.
// MATVEC_SATURATE_EN selects clamping instead of truncation of the result.
module matvec_mac
  import matvec_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int A_COLS = A_COLS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  output logic [ELEM_W-1:0] result
);

  localparam int ACC_W = acc_width(ELEM_W, A_COLS);

  logic [2*ELEM_W-1:0] prod;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;

  assign prod = a * b;
  assign sum  = (clr ? '0 : acc) + ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (reset) acc <= '0;
    else if (en) acc <= sum;
  end

  // The result is taken from the running sum so the row word is ready on the
  // same edge that performs the row's final MAC.
`ifdef MATVEC_SATURATE_EN
  logic [ACC_W-9:0] shifted;
  logic [7:0]       unused_low;

  assign shifted    = sum[ACC_W-1:8];
  assign unused_low = sum[7:0];
  assign result     = (|shifted[ACC_W-9:ELEM_W]) ? '1 : shifted[ELEM_W-1:0];
`else
  logic [7:0]              unused_low;
  logic [ACC_W-ELEM_W-9:0] unused_high;

  assign unused_low  = sum[7:0];
  assign unused_high = sum[ACC_W-1:ELEM_W+8];
  assign result      = sum[ELEM_W+7:8];
`endif

endmodule

// File: rtl/matvec_axis_coproc.sv
// AXI4-Stream matrix-vector coprocessor: load A then B, compute (A*B)>>8 per row, stream rows out.
// Build option MATVEC_SATURATE_EN (see matvec_mac) clamps results instead of truncating.
module matvec_axis_coproc
  import matvec_pkg::*;
#(
  parameter int A_ROWS = A_ROWS_DEF,
  parameter int A_COLS = A_COLS_DEF,
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int AXIS_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  output logic              S_AXIS_TREADY,
  input  logic [AXIS_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              M_AXIS_TVALID,
  output logic [AXIS_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY
);

  localparam int RW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;
  localparam int CW = (A_COLS > 1) ? $clog2(A_COLS) : 1;

  state_t          state, state_nxt;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic            b_phase;
  logic            tready_q;
  logic            in_hs, out_hs, row_last, col_last;
  logic            mac_en, mac_clr;
  logic [ELEM_W-1:0] mac_a, mac_b, mac_result;

  logic [ELEM_W-1:0] a_mem   [A_ROWS][A_COLS];
  logic [ELEM_W-1:0] b_mem   [A_COLS];
  logic [ELEM_W-1:0] res_mem [A_ROWS];

  logic unused_in;
  assign unused_in = ^{S_AXIS_TDATA[AXIS_W-1:ELEM_W], S_AXIS_TLAST};

  assign row_last = (row == RW'(A_ROWS - 1));
  assign col_last = (col == CW'(A_COLS - 1));
  assign in_hs    = S_AXIS_TVALID & tready_q;
  assign out_hs   = M_AXIS_TVALID & M_AXIS_TREADY;

  assign S_AXIS_TREADY = tready_q;
  assign M_AXIS_TVALID = (state == WRITE_OUTPUTS);
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? AXIS_W'(res_mem[row]) : '0;
  assign M_AXIS_TLAST  = M_AXIS_TVALID & row_last;

  always_comb begin
    state_nxt = state;
    unique case (state)
      READ_INPUTS:   if (in_hs && b_phase && col_last) state_nxt = COMPUTE;
      COMPUTE:       if (row_last && col_last)         state_nxt = WRITE_OUTPUTS;
      WRITE_OUTPUTS: if (out_hs && row_last)           state_nxt = READ_INPUTS;
      default:                                         state_nxt = READ_INPUTS;
    endcase
  end

  // row/col index A while loading, col alone indexes B, and row doubles as
  // the output word index while draining.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= READ_INPUTS;
      row      <= '0;
      col      <= '0;
      b_phase  <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tready_q <= (state_nxt == READ_INPUTS);
      unique case (state)
        READ_INPUTS: begin
          if (in_hs) begin
            if (col_last) begin
              col <= '0;
              if (b_phase) begin
                b_phase <= 1'b0;
              end else if (row_last) begin
                row     <= '0;
                b_phase <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        COMPUTE: begin
          if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        WRITE_OUTPUTS: begin
          if (out_hs) row <= row_last ? '0 : row + RW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (in_hs) begin
      if (b_phase) b_mem[col]      <= S_AXIS_TDATA[ELEM_W-1:0];
      else         a_mem[row][col] <= S_AXIS_TDATA[ELEM_W-1:0];
    end
    if (state == COMPUTE && col_last) res_mem[row] <= mac_result;
  end

  assign mac_en  = (state == COMPUTE);
  assign mac_clr = (col == '0);
  assign mac_a   = a_mem[row][col];
  assign mac_b   = b_mem[col];

  matvec_mac #(
    .ELEM_W (ELEM_W),
    .A_COLS (A_COLS)
  ) u_mac (
    .clk    (ACLK),
    .reset  (ARESET),
    .en     (mac_en),
    .clr    (mac_clr),
    .a      (mac_a),
    .b      (mac_b),
    .result (mac_result)
  );

endmodule

// File: tb/tb_matvec_axis_coproc.sv
// Directed plus randomized bench for matvec_axis_coproc against an arithmetic reference model.
module tb_matvec_axis_coproc;

  localparam int R = 2;
  localparam int C = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        M_AXIS_TVALID;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;

  matvec_axis_coproc dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] va [R*C];
  logic [7:0] vb [C];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row result from the arithmetic definition: dot product, drop 8 LSBs, fit to 8 bits.
  function automatic logic [31:0] model(input int r);
    int unsigned acc = 0;
    for (int c = 0; c < C; c++) acc += int'(va[r*C+c]) * int'(vb[c]);
    acc = acc >> 8;
`ifdef MATVEC_SATURATE_EN
    if (acc > 255) acc = 255;
`endif
    return acc & 32'hFF;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic l, output int e);
    int n = 0;
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    while (!S_AXIS_TREADY && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 100) check("in_ready_timeout", 32'(n), 32'd0);
    @(posedge ACLK);
    @(negedge ACLK);
    e = cyc;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic run_vec(input string name, input int gap_after, input bit junk,
                         input int bp, input bit chk_lat);
    int e = 0;
    int n;
    logic [31:0] exp_d, held_d;
    logic held_l;
    for (int i = 0; i < R*C + C; i++) begin
      logic [7:0] el;
      el = (i < R*C) ? va[i] : vb[i-R*C];
      send_word({junk ? 24'hABCDEF : 24'h0, el}, junk && (i == 2), e);
      if (i == gap_after) repeat (2) @(negedge ACLK);
    end
    check({name, "_compute_tready"}, 32'(S_AXIS_TREADY), 32'd0);
    M_AXIS_TREADY = (bp == 0);
    n = 0;
    while (!M_AXIS_TVALID && n < 100) begin
      @(negedge ACLK);
      n++;
    end
    if (chk_lat) check({name, "_latency"}, 32'(cyc - e), 32'd8);
    for (int k = 0; k < R; k++) begin
      n = 0;
      while (!M_AXIS_TVALID && n < 100) begin
        @(negedge ACLK);
        n++;
      end
      exp_d = model(k);
      check($sformatf("%s_tvalid%0d", name, k), 32'(M_AXIS_TVALID), 32'd1);
      check($sformatf("%s_tdata%0d", name, k), M_AXIS_TDATA, exp_d);
      check($sformatf("%s_tlast%0d", name, k), 32'(M_AXIS_TLAST), 32'(k == R-1));
      if (k == 0 && bp > 0) begin
        held_d = M_AXIS_TDATA;
        held_l = M_AXIS_TLAST;
        repeat (bp) begin
          @(negedge ACLK);
          check({name, "_bp_tvalid"}, 32'(M_AXIS_TVALID), 32'd1);
          check({name, "_bp_tdata"}, M_AXIS_TDATA, held_d);
          check({name, "_bp_tlast"}, 32'(M_AXIS_TLAST), 32'(held_l));
        end
        M_AXIS_TREADY = 1'b1;
      end
      @(posedge ACLK);
      @(negedge ACLK);
    end
    check({name, "_end_tvalid"}, 32'(M_AXIS_TVALID), 32'd0);
    check({name, "_end_tready"}, 32'(S_AXIS_TREADY), 32'd1);
  endtask

  task automatic load_basic();
    logic [7:0] ba [R*C] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < R*C; i++) va[i] = ba[i];
    for (int c = 0; c < C; c++) vb[c] = 8'h10;
  endtask

  task automatic load_random();
    for (int i = 0; i < R*C; i++) va[i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < C; c++) vb[c] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    int e;
    repeat (3) @(negedge ACLK);
    check("rst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("rst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_m_tdata", M_AXIS_TDATA, 32'd0);
    check("rst_m_tlast", 32'(M_AXIS_TLAST), 32'd0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("post_rst_tready", 32'(S_AXIS_TREADY), 32'd1);

    load_basic();
    check("basic_ref0", model(0), 32'h0A);
    check("basic_ref1", model(1), 32'h00);
    run_vec("basic", -1, 1'b0, 0, 1'b1);

    for (int i = 0; i < R*C; i++) va[i] = 8'hFF;
    for (int c = 0; c < C; c++) vb[c] = 8'hFF;
    run_vec("overflow", -1, 1'b0, 0, 1'b1);

    load_random();
    run_vec("backpressure", -1, 1'b0, 3, 1'b1);

    load_basic();
    run_vec("gap_junk", 4, 1'b1, 0, 1'b1);

    load_random();
    run_vec("b2b_first", -1, 1'b0, 0, 1'b0);
    load_random();
    run_vec("b2b_second", -1, 1'b0, 0, 1'b1);

    for (int i = 0; i < 6; i++) send_word(32'($urandom_range(0, 255)), 1'b0, e);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("midrst_s_tready", 32'(S_AXIS_TREADY), 32'd0);
    check("midrst_m_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("midrst_m_tdata", M_AXIS_TDATA, 32'd0);
    check("midrst_m_tlast", 32'(M_AXIS_TLAST), 32'd0);
    ARESET = 1'b0;
    load_basic();
    run_vec("after_midrst", -1, 1'b0, 0, 1'b1);

    for (int t = 0; t < 6; t++) begin
      load_random();
      run_vec($sformatf("rand%0d", t), int'($urandom_range(0, 14)) - 1, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matvec_axis_coproc.md
# matvec_axis_coproc

AXI4-Stream matrix-vector coprocessor: receives matrix A (A_ROWS×A_COLS) then vector B (A_COLS) on a slave stream, computes RES = (A·B) >> 8 per row, and returns A_ROWS result words on a master stream. It is the responder behind the matrix-multiplication stream interface. It sits between the DMA/stream source that feeds S_AXIS and the sink that drains M_AXIS. Processing is strictly sequential: read all inputs, compute, write all outputs.

## Interface
- A_ROWS, 2, rows of A = number of output words
- A_COLS, 4, columns of A = length of B
- ELEM_W, 8, unsigned element and result width, carried in TDATA[ELEM_W-1:0]
- AXIS_W, 32, stream data width
- ACLK  in  1  single clock, all logic on rising edge
- ARESET  in  1  synchronous, active-high reset
- S_AXIS_TREADY  out  1  ready to accept input word
- S_AXIS_TDATA  in  AXIS_W  input word; bits above ELEM_W ignored
- S_AXIS_TLAST  in  1  ignored (word count is fixed)
- S_AXIS_TVALID  in  1  input word valid
- M_AXIS_TVALID  out  1  output word valid
- M_AXIS_TDATA  out  AXIS_W  result, zero-extended above ELEM_W
- M_AXIS_TLAST  out  1  high on the final (A_ROWS-th) output word
- M_AXIS_TREADY  in  1  downstream ready

## Operation
- States: READ_INPUTS, COMPUTE, WRITE_OUTPUTS.
- READ_INPUTS: S_AXIS_TREADY=1. Each TVALID&TREADY edge stores one word. The first A_ROWS·A_COLS words go to A, row-major. The next A_COLS words go to B. After the last B word, go to COMPUTE.
- COMPUTE: TREADY=0. One MAC per cycle, row-major over (row, col), A_ROWS·A_COLS cycles total. The accumulator clears at col 0. At col A_COLS-1 the row result is written to RES[row]. After the last MAC, go to WRITE_OUTPUTS.
- Arithmetic: product is 2·ELEM_W bits. The accumulator is 2·ELEM_W+clog2(A_COLS) bits with no overflow. Result = acc[ELEM_W+7:8], post-processed per Configuration.
- WRITE_OUTPUTS: M_AXIS_TVALID=1 and TDATA=RES[k]. k advances on each TVALID&TREADY edge. TLAST=1 when k=A_ROWS-1. After the TLAST handshake, return to READ_INPUTS.
- S_AXIS_TLAST, including an early TLAST, has no effect.
- Input and output phases never overlap. Input TVALID during COMPUTE or WRITE_OUTPUTS is not accepted.

## Timing
- Reset values: S_AXIS_TREADY=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0. State=READ_INPUTS, all counters 0.
- S_AXIS_TREADY is 1 in the first cycle after ARESET deasserts.
- Let E be the edge accepting the last B word. COMPUTE occupies edges E+1..E+A_ROWS·A_COLS. M_AXIS_TVALID is high after edge E+A_ROWS·A_COLS; the default latency is 8 cycles.
- Backpressure: while TVALID=1 and TREADY=0, TDATA and TLAST hold stable.
- After the final output handshake edge, TVALID=0 and TREADY=1 in the next cycle; no idle cycle.
- TVALID gaps on input stall counting without corrupting stored words.
- ARESET mid-operation, in any state: abort, return to the reset values on the next edge, and discard partial data.

## Configuration
- MATVEC_SATURATE_EN defined: if acc >> 8 exceeds 2^ELEM_W-1, the result is 2^ELEM_W-1.
- MATVEC_SATURATE_EN undefined: the result is truncated to bits [ELEM_W+7:8].

## Structure
- Package matvec_pkg holds:
  - the state enum (READ_INPUTS, COMPUTE, WRITE_OUTPUTS);
  - default A_ROWS, A_COLS and ELEM_W constants;
  - the accumulator-width function.
- Sub-module matvec_mac: registered multiply-accumulate with clear, and the shift/saturate result stage (macro-dependent).
- Top level holds the A, B and RES register arrays, the FSM and the counters.

## Test plan
- Basic: A rows {10,20,30,40} and {01,02,03,04} hex, B = {10,10,10,10} hex. Expect outputs 0x0A then 0x00. TLAST on the second word only. TVALID 8 cycles after the last input edge.
- Overflow: A all 0xFF, B all 0xFF (acc = 260100). With MATVEC_SATURATE_EN, both outputs are 0xFF. Without it, both are 0xF8.
- Backpressure: hold M_AXIS_TREADY=0 for 3 cycles while TVALID=1. Expect TDATA and TLAST stable, no word lost or duplicated.
- Input gaps and junk: drop S_AXIS_TVALID for 2 cycles after word 5. Set TDATA[31:8]=0xABCDEF and an early TLAST at word 3. Expect results identical to the Basic case.
- Back-to-back: send two vectors with no idle cycles. Expect TREADY=1 the cycle after the first TLAST handshake, and correct results for both.
- Reset mid-input: assert ARESET after 6 input words, then send a full Basic vector. Expect all outputs 0 during reset, then Basic results.
